// File: rtl/npc_pcgen_exc.sv
// npc_pcgen_exc: fetch-address generator for the F stage.
//   Owns the F-stage PC register and resolves the D-stage branch/jump
//   (condition + target). It also handles exception entry and ERET
//   return, tracks whether the instruction now in D is a delay slot, and
//   flags illegal fetch addresses.
// Optional feature: define NPC_PERF_CNT_EN to add the perf_taken and
// perf_stall event counters.
module npc_pcgen_exc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO    = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI    = 32'h0000_6FFC,
  parameter int          OFFS_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  output logic [31:0]       pc_f,
  input  logic [31:0]       pc_d,
  input  logic [OFFS_W-1:0] offs,
  input  logic [25:0]       imm26,
  input  logic [31:0]       reg_tgt,
  input  logic [2:0]        npc_op,
  input  logic [2:0]        npc_cond,
  input  logic              eq,
  input  logic              lt,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [31:0]       epc,
  output logic              bd_d,
  output logic              adel_f,
  output logic              taken_d
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [31:0]       perf_taken,
  output logic [31:0]       perf_stall
`endif
);

  // Control-transfer kind of the instruction in D; codes 4-7 act as seq.
  typedef enum logic [2:0] {
    OP_SEQ = 3'd0,
    OP_BR  = 3'd1,
    OP_J26 = 3'd2,
    OP_REG = 3'd3
  } npc_op_e;

  // Branch condition selector; codes 6-7 are never taken.
  typedef enum logic [2:0] {
    CND_ALWAYS = 3'd0,
    CND_EQ     = 3'd1,
    CND_LT     = 3'd2,
    CND_GT     = 3'd3,
    CND_LE     = 3'd4,
    CND_GE     = 3'd5
  } npc_cond_e;

  logic [31:0] pc_f_q, pc_f_d;
  logic        bd_q, bd_d_nx;

  logic        is_xfer;
  logic        cond_true;
  logic [31:0] offs_sext;
  logic [31:0] seq_tgt;
  logic [31:0] br_tgt;
  logic [31:0] j26_tgt;
  logic [31:0] xfer_tgt;

  // Target arithmetic: every candidate is computed and then selected.
  assign offs_sext = {{(32-OFFS_W){offs[OFFS_W-1]}}, offs};
  assign seq_tgt   = pc_f_q + 32'd4;
  assign br_tgt    = pc_d + 32'd4 + {offs_sext[29:0], 2'b00};
  assign j26_tgt   = {pc_d[31:28], imm26, 2'b00};

  // Decode whether D holds a control transfer and whether its condition holds.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    is_xfer   = 1'b0;
    cond_true = 1'b0;
    case (npc_op)
      OP_BR, OP_J26, OP_REG: is_xfer = 1'b1;
      default:               is_xfer = 1'b0;
    endcase
    case (npc_cond)
      CND_ALWAYS: cond_true = 1'b1;
      CND_EQ:     cond_true = eq;
      CND_LT:     cond_true = lt;
      CND_GT:     cond_true = !eq && !lt;
      CND_LE:     cond_true = eq || lt;
      CND_GE:     cond_true = !lt;
      default:    cond_true = 1'b0;
    endcase
  end

  assign taken_d = is_xfer && cond_true;

  // Select the transfer target for a taken D instruction.
  always_comb begin
    xfer_tgt = seq_tgt;
    case (npc_op)
      OP_BR:   xfer_tgt = br_tgt;
      OP_J26:  xfer_tgt = j26_tgt;
      OP_REG:  xfer_tgt = reg_tgt;   // misalignment surfaces later as adel_f
      default: xfer_tgt = seq_tgt;
    endcase
  end

  // Next PC and delay-slot flag: exception > ERET > stall > taken > sequential.
  always_comb begin
    pc_f_d  = seq_tgt;
    bd_d_nx = is_xfer;
    if (exc_req) begin
      pc_f_d  = HANDLER_PC;
      bd_d_nx = 1'b0;
    end else if (eret_req) begin
      pc_f_d  = epc;
      bd_d_nx = 1'b0;
    end else if (stall) begin
      pc_f_d  = pc_f_q;
      bd_d_nx = bd_q;
    end else if (taken_d) begin
      pc_f_d  = xfer_tgt;
    end
  end

  // PC and delay-slot state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q <= RESET_PC;
      bd_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      pc_f_q <= pc_f_d;
      bd_q   <= bd_d_nx;
    end
  end

  assign pc_f = pc_f_q;
  assign bd_d = bd_q;

  // Fetch-address check; the PC keeps advancing and CP0 takes the exception.
  assign adel_f = (pc_f_q[1:0] != 2'b00) || (pc_f_q < IMEM_LO) || (pc_f_q > IMEM_HI);

`ifdef NPC_PERF_CNT_EN
  logic [31:0] perf_taken_q, perf_stall_q;
  logic        redirect;

  assign redirect = exc_req || eret_req;

  // Event counters; exception/ERET edges are not counted, both wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_taken_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else if (!redirect) begin
      if (stall)        perf_stall_q <= perf_stall_q + 32'd1;
      else if (taken_d) perf_taken_q <= perf_taken_q + 32'd1;
    end
  end

  assign perf_taken = perf_taken_q;
  assign perf_stall = perf_stall_q;
`else
  // Counters not built: no extra state or ports.
`endif

endmodule

// File: tb/tb_npc_pcgen_exc.sv
// Self-checking bench for npc_pcgen_exc: directed steps followed by random
// traffic, compared against a behavioural model of the PC rules.
module tb_npc_pcgen_exc;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO    = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI    = 32'h0000_6FFC;

  logic        clk, reset, stall;
  logic [31:0] pc_f, pc_d, reg_tgt, epc;
  logic [15:0] offs;
  logic [25:0] imm26;
  logic [2:0]  npc_op, npc_cond;
  logic        eq, lt, exc_req, eret_req;
  logic        bd_d, adel_f, taken_d;
`ifdef NPC_PERF_CNT_EN
  logic [31:0] perf_taken, perf_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference state.
  logic [31:0] m_pc;
  logic        m_bd;
  logic [31:0] m_ptaken, m_pstall;

  npc_pcgen_exc dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_f(pc_f), .pc_d(pc_d),
    .offs(offs), .imm26(imm26), .reg_tgt(reg_tgt), .npc_op(npc_op),
    .npc_cond(npc_cond), .eq(eq), .lt(lt), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .bd_d(bd_d), .adel_f(adel_f),
    .taken_d(taken_d)
`ifdef NPC_PERF_CNT_EN
    , .perf_taken(perf_taken), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic ref_taken();
    logic c;
    case (npc_cond)
      3'd0:    c = 1'b1;
      3'd1:    c = eq;
      3'd2:    c = lt;
      3'd3:    c = !eq && !lt;
      3'd4:    c = eq || lt;
      3'd5:    c = !lt;
      default: c = 1'b0;
    endcase
    return (npc_op >= 3'd1) && (npc_op <= 3'd3) && c;
  endfunction

  function automatic logic [31:0] ref_target();
    int so;
    so = int'($signed(offs));
    case (npc_op)
      3'd1:    return pc_d + 32'd4 + 32'(so * 4);
      3'd2:    return {pc_d[31:28], imm26, 2'b00};
      3'd3:    return reg_tgt;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  function automatic logic ref_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_bd = 1'b0; m_ptaken = 32'd0; m_pstall = 32'd0;
  endtask

  task automatic model_edge();
    logic tk;
    tk = ref_taken();
    if (exc_req) begin
      m_pc = HANDLER_PC; m_bd = 1'b0;
    end else if (eret_req) begin
      m_pc = epc; m_bd = 1'b0;
    end else if (stall) begin
      m_pstall = m_pstall + 32'd1;
    end else begin
      if (tk) begin
        m_ptaken = m_ptaken + 32'd1;
        m_pc = ref_target();
      end else begin
        m_pc = m_pc + 32'd4;
      end
      m_bd = (npc_op >= 3'd1) && (npc_op <= 3'd3);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".pc_f"},   pc_f,   m_pc);
    check({tag, ".bd_d"},   32'(bd_d),   32'(m_bd));
    check({tag, ".adel_f"}, 32'(adel_f), 32'(ref_adel(m_pc)));
`ifdef NPC_PERF_CNT_EN
    check({tag, ".perf_taken"}, perf_taken, m_ptaken);
    check({tag, ".perf_stall"}, perf_stall, m_pstall);
`endif
  endtask

  // Inputs are already applied just after an edge; check taken_d, clock once, check state.
  task automatic cycle(input string tag);
    #1;
    check({tag, ".taken_d"}, 32'(taken_d), 32'(ref_taken()));
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    stall = 0; pc_d = 32'd0; offs = 16'd0; imm26 = 26'd0; reg_tgt = 32'd0;
    npc_op = 3'd0; npc_cond = 3'd0; eq = 0; lt = 0;
    exc_req = 0; eret_req = 0; epc = 32'd0;
  endtask

  // Pulse reset between clock edges and check its effect before any edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_state(tag);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #11;
    check_state("reset");
    check("reset.pc_const", pc_f, 32'h0000_3000);
    reset = 1'b0;
    #1;

    // Sequential fetch after reset.
    cycle("seq1"); check("seq1.const", pc_f, 32'h3004);
    cycle("seq2"); check("seq2.const", pc_f, 32'h3008);

    // Taken beq backward: 0x3004+4-8.
    pc_d = 32'h3004; npc_op = 3'd1; npc_cond = 3'd1; eq = 1; offs = 16'hFFFE;
    cycle("br_taken");
    check("br_taken.pc_const", pc_f, 32'h3000);
    check("br_taken.bd_const", 32'(bd_d), 32'd1);
    eq = 0;
    cycle("br_not");
    check("br_not.pc_const", pc_f, 32'h3004);
    check("br_not.bd_const", 32'(bd_d), 32'd1);

    // Condition table corners.
    npc_cond = 3'd3; eq = 0; lt = 0; #1;
    check("cond_gt.const", 32'(taken_d), 32'd1);
    cycle("cond_gt");
    npc_cond = 3'd4; eq = 1; lt = 0; #1;
    check("cond_le.const", 32'(taken_d), 32'd1);
    cycle("cond_le");
    npc_cond = 3'd6; eq = 1; lt = 1; #1;
    check("cond_never.const", 32'(taken_d), 32'd0);
    cycle("cond_never");
    npc_op = 3'd5; npc_cond = 3'd0; #1;
    check("op5_seq.const", 32'(taken_d), 32'd0);
    cycle("op5_seq");
    check("op5_seq.bd_const", 32'(bd_d), 32'd0);

    // Register jump to a misaligned address.
    npc_op = 3'd3; npc_cond = 3'd0; reg_tgt = 32'h3402;
    cycle("jr_mis");
    check("jr_mis.pc_const", pc_f, 32'h3402);
    check("jr_mis.adel_const", 32'(adel_f), 32'd1);

    // Stall holds PC and bd_d.
    idle(); stall = 1; npc_op = 3'd1; eq = 1;
    cycle("stall1");
    cycle("stall2");
    check("stall2.pc_const", pc_f, 32'h3402);
    check("stall2.bd_const", 32'(bd_d), 32'd1);

    // Exception beats stall; exception beats ERET.
    exc_req = 1;
    cycle("exc_stall");
    check("exc_stall.pc_const", pc_f, 32'h4180);
    check("exc_stall.bd_const", 32'(bd_d), 32'd0);
    idle(); npc_op = 3'd2; cycle("pre_both");
    idle(); exc_req = 1; eret_req = 1; epc = 32'h3010;
    cycle("exc_eret");
    check("exc_eret.pc_const", pc_f, 32'h4180);

    // ERET return, then asynchronous reset between edges.
    idle(); eret_req = 1; epc = 32'h3010; stall = 1;
    cycle("eret");
    check("eret.pc_const", pc_f, 32'h3010);
    idle();
    async_reset("async_rst");
    check("async_rst.pc_const", pc_f, 32'h3000);

    // Sequential wrap at the top of the address space.
    reg_tgt = 32'hFFFF_FFFC; npc_op = 3'd3;
    cycle("to_top");
    idle();
    cycle("wrap");
    check("wrap.pc_const", pc_f, 32'h0000_0000);

`ifdef NPC_PERF_CNT_EN
    async_reset("perf_clr0");
    for (int i = 0; i < 3; i++) begin
      idle(); npc_op = 3'd2; imm26 = 26'(32'h0C00 + i);
      cycle("perf_tk");
    end
    for (int i = 0; i < 4; i++) begin
      idle(); stall = 1;
      cycle("perf_st");
    end
    check("perf_taken.const", perf_taken, 32'd3);
    check("perf_stall.const", perf_stall, 32'd4);
    idle();
    async_reset("perf_clr");
    check("perf_clr.taken_const", perf_taken, 32'd0);
    check("perf_clr.stall_const", perf_stall, 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom_range(0, 4) == 0);
      exc_req  = ($urandom_range(0, 19) == 0);
      eret_req = ($urandom_range(0, 19) == 0);
      npc_op   = 3'($urandom_range(0, 7));
      npc_cond = 3'($urandom_range(0, 7));
      eq       = 1'($urandom_range(0, 1));
      lt       = 1'($urandom_range(0, 1));
      pc_d     = 32'h3000 + 32'($urandom_range(0, 16'h3FFF)) * 32'd4;
      offs     = 16'($urandom);
      imm26    = 26'($urandom);
      reg_tgt  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h3000 + 32'($urandom_range(0, 16'h4000));
      epc      = ($urandom_range(0, 1) == 0) ? 32'h3000 + 32'($urandom_range(0, 16'h0FFF)) * 32'd4 : 32'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
      end
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
